ddr4_cmd_arbiter: RTL

- Shares one external DDR4 command/data channel between NUM_REQ processor core instances using round-robin arbitration.
- Holds the winning command in a registered output stage until the memory accepts it.
- Tracks outstanding reads in an in-order ID FIFO and routes each read beat back to the requester that issued it.
- Sits between the per-core ext_ddr4 ports and the single memory-controller port.

---
 rtl/ddr4_arb_pkg.sv | 14 +
 rtl/arb_id_fifo.sv | 57 +++++
 rtl/ddr4_cmd_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ddr4_arb_pkg.sv
// Shared constants and helpers for the DDR4 command arbiter.
`timescale 1ns/1ps
package ddr4_arb_pkg;

    localparam int NUM_REQ_MAX = 8;

    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of requester IDs for outstanding reads.
`timescale 1ns/1ps
module arb_id_fifo
    import ddr4_arb_pkg::*;
#(
    parameter int ID_W  = 2,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [ID_W-1:0]  push_id,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [ID_W-1:0]  head
);

    logic [ID_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign pop_ok  = pop && !empty;
    // A push into a full FIFO is only legal when a pop frees the slot.
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr4_cmd_arbiter.sv
// Round-robin arbiter sharing one DDR4 command channel among NUM_REQ cores.
// Define ARB_PERF_CNT_EN to add per-requester grant and stall counters.
`timescale 1ns/1ps
module ddr4_cmd_arbiter
    import ddr4_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 512,
    parameter int RD_OUTSTANDING = 8,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic                      core_clk_main_800mhz,
    input  logic                      core_reset_async_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ*STRB_W-1:0] req_wstrb,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ADDR_W-1:0]         ext_ddr4_addr_bus,
    output logic [DATA_W-1:0]         ext_ddr4_write_data,
    output logic [STRB_W-1:0]         ext_ddr4_write_strobe,
    output logic                      ext_ddr4_command_valid,
    output logic                      ext_ddr4_command_write_enable,
    input  logic                      ext_ddr4_command_ready,
    input  logic [DATA_W-1:0]         ext_ddr4_read_data,
    input  logic                      ext_ddr4_read_valid,
    output logic                      arb_busy,
    output logic                      err_unexpected_rsp
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [NUM_REQ*32-1:0]     perf_grant_count,
    output logic [31:0]               perf_stall_cycles
`endif
);

    localparam int ID_W  = id_width(NUM_REQ);
    localparam int CNT_W = $clog2(RD_OUTSTANDING) + 1;

    logic                clk;
    logic                rst_n;
    logic                load_en;
    logic                found;
    int                  idx;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     win_id;
    logic [ID_W-1:0]     prio;
    logic [ID_W-1:0]     next_prio;
    logic [ID_W-1:0]     cmd_id;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [STRB_W-1:0]   sel_wstrb;
    logic                sel_write;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic [ID_W-1:0]     fifo_head;

    assign clk   = core_clk_main_800mhz;
    assign rst_n = core_reset_async_n;

    // prio is the first index scanned: one past the last winner.
    always_comb begin
        grant     = '0;
        found     = 1'b0;
        idx       = 0;
        win_id    = '0;
        next_prio = prio;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        sel_write = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(prio) + k) % NUM_REQ;
            if (!found && req_valid[idx] && (req_write[idx] || !fifo_full)) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win_id     = ID_W'(idx);
                next_prio  = ID_W'((idx + 1) % NUM_REQ);
                sel_addr   = req_addr[idx*ADDR_W +: ADDR_W];
                sel_wdata  = req_wdata[idx*DATA_W +: DATA_W];
                sel_wstrb  = req_wstrb[idx*STRB_W +: STRB_W];
                sel_write  = req_write[idx];
            end
        end
    end

    assign load_en   = rst_n && (!ext_ddr4_command_valid || ext_ddr4_command_ready);
    assign req_ready = load_en ? grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio                          <= '0;
            cmd_id                        <= '0;
            ext_ddr4_command_valid        <= 1'b0;
            ext_ddr4_command_write_enable <= 1'b0;
            ext_ddr4_addr_bus             <= '0;
            ext_ddr4_write_data           <= '0;
            ext_ddr4_write_strobe         <= '0;
        end else if (load_en && found) begin
            prio                          <= next_prio;
            cmd_id                        <= win_id;
            ext_ddr4_command_valid        <= 1'b1;
            ext_ddr4_command_write_enable <= sel_write;
            ext_ddr4_addr_bus             <= sel_addr;
            ext_ddr4_write_data           <= sel_wdata;
            ext_ddr4_write_strobe         <= sel_wstrb;
        end else if (ext_ddr4_command_ready) begin
            ext_ddr4_command_valid        <= 1'b0;
        end
    end

    assign fifo_push = ext_ddr4_command_valid && ext_ddr4_command_ready
                    && (ext_ddr4_command_write_enable == CMD_RD);
    assign fifo_pop  = ext_ddr4_read_valid && !fifo_empty;

    arb_id_fifo #(
        .ID_W  (ID_W),
        .DEPTH (RD_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .push_id (cmd_id),
        .pop     (fifo_pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count),
        .head    (fifo_head)
    );

    assign arb_busy = ext_ddr4_command_valid || (fifo_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid          <= '0;
            rsp_data           <= '0;
            err_unexpected_rsp <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (fifo_pop) begin
                rsp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << fifo_head;
                rsp_data  <= ext_ddr4_read_data;
            end else if (ext_ddr4_read_valid) begin
                err_unexpected_rsp <= 1'b1;
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_grant_count  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) begin
                    perf_grant_count[i*32 +: 32] <= perf_grant_count[i*32 +: 32] + 32'd1;
                end
            end
            if (ext_ddr4_command_valid && !ext_ddr4_command_ready) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
